qdr_user_app_responder: RTL and testbench

- Synthesizable responder for the QDR user-application interface driven by the generator datapath's store/replay logic.
- Accepts write and read commands, backs them with on-chip memory, and returns read data after a fixed, parameterized latency.
- Emulates calibration completion after a programmable delay.
- Replaces the external QDR controller in simulation and FPGA loopback builds. The datapath's wr/rd command ports connect to it directly.

---
 rtl/qdr_user_app_responder_if.sv | 37 +++
 rtl/qdr_user_app_responder.sv | 163 ++++++++++++++++
 tb/tb_qdr_user_app_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/qdr_user_app_responder_if.sv
// Purpose : QDR user-application command/response bundle between the
//           generator datapath (master) and the responder (slave).
// Signals : user_app_wr_cmd/addr/data  - write command strobe, address, data
//           user_app_rd_cmd/addr       - read command strobe, address
//           user_app_rd_valid/data     - read response (one cycle per command)
//           init_calib_complete        - calibration done flag
//           wr_count/rd_count/drop_count - accepted/dropped command counters
interface qdr_user_app_responder_if #(
  parameter int AW = 19,
  parameter int PW = 144
);
  logic          user_app_wr_cmd;
  logic [AW-1:0] user_app_wr_addr;
  logic [PW-1:0] user_app_wr_data;
  logic          user_app_rd_cmd;
  logic [AW-1:0] user_app_rd_addr;
  logic          user_app_rd_valid;
  logic [PW-1:0] user_app_rd_data;
  logic          init_calib_complete;
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;
  logic [31:0]   drop_count;

  modport master (
    output user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
    output user_app_rd_cmd, user_app_rd_addr,
    input  user_app_rd_valid, user_app_rd_data, init_calib_complete,
    input  wr_count, rd_count, drop_count
  );

  modport slave (
    input  user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
    input  user_app_rd_cmd, user_app_rd_addr,
    output user_app_rd_valid, user_app_rd_data, init_calib_complete,
    output wr_count, rd_count, drop_count
  );
endinterface

// File: rtl/qdr_user_app_responder.sv
// Purpose : Stand-in for an external QDR controller. Backs write/read
//           commands with on-chip memory, returns read data after a fixed
//           RD_LATENCY and raises init_calib_complete after CALIB_CYCLES.
// Ports   : clk    - clock
//           resetn - synchronous active-low reset
//           app    - slave side of qdr_user_app_responder_if
module qdr_user_app_responder #(
  parameter int QDR_ADDR_WIDTH   = 19,
  parameter int QDR_DATA_WIDTH   = 36,
  parameter int QDR_BURST_LENGTH = 4,
  parameter int MEM_ADDR_BITS    = 12,
  parameter int RD_LATENCY       = 4,
  parameter int CALIB_CYCLES     = 64
) (
  input logic                     clk,
  input logic                     resetn,
  qdr_user_app_responder_if.slave app
);

  localparam int PW    = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam int CW    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);

  typedef enum logic [0:0] {ST_CALIB = 1'b0, ST_READY = 1'b1} state_e;

  // Saturating add so counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, v} + {31'd0, inc};
    if (sum[32]) begin
      sat_add = 32'hFFFF_FFFF;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   calib_cnt_q, calib_cnt_d;
  logic            calib_done_q, calib_done_d;
  logic [31:0]     wr_count_q, wr_count_d;
  logic [31:0]     rd_count_q, rd_count_d;
  logic [31:0]     drop_count_q, drop_count_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]   dat_q [RD_LATENCY];
  logic [PW-1:0]   dat_d [RD_LATENCY];
  logic [PW-1:0]   mem   [DEPTH];

  logic                     wr_acc_s, rd_acc_s;
  logic [1:0]               drop_inc_s;
  logic [MEM_ADDR_BITS-1:0] wr_idx_s, rd_idx_s;
  logic [PW-1:0]            rd_word_s;

  // Calibration FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_CALIB;
      calib_cnt_q <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
    end
  end

  // Calibration FSM next state: count up, leave CALIB on the last count.
  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    case (state_q)
      ST_CALIB: begin
        if (calib_cnt_q == CALIB_LAST) begin
          state_d = ST_READY;
        end else begin
          calib_cnt_d = calib_cnt_q + CW'(1);
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CALIB;
    endcase
  end

  // Calibration FSM output: done flag is registered one cycle after READY.
  always_comb begin
    case (state_q)
      ST_READY: calib_done_d = 1'b1;
      ST_CALIB: calib_done_d = 1'b0;
      default:  calib_done_d = 1'b0;
    endcase
  end

  // Only the low MEM_ADDR_BITS are decoded, so addresses alias modulo depth.
  assign wr_idx_s   = app.user_app_wr_addr[MEM_ADDR_BITS-1:0];
  assign rd_idx_s   = app.user_app_rd_addr[MEM_ADDR_BITS-1:0];
  assign wr_acc_s   = app.user_app_wr_cmd & calib_done_q;
  assign rd_acc_s   = app.user_app_rd_cmd & calib_done_q;
  assign drop_inc_s = {1'b0, app.user_app_wr_cmd & ~calib_done_q}
                    + {1'b0, app.user_app_rd_cmd & ~calib_done_q};
  // Sampled before the same-edge write lands, giving read-before-write.
  assign rd_word_s  = mem[rd_idx_s];

  // Backing store; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_acc_s) begin
      mem[wr_idx_s] <= app.user_app_wr_data;
    end
  end

  // Read pipeline and counter next-state; data stage carries zero when idle.
  always_comb begin
    vld_d[0] = rd_acc_s;
    if (rd_acc_s) begin
      dat_d[0] = rd_word_s;
    end else begin
      dat_d[0] = {PW{1'b0}};
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (wr_acc_s) begin
      wr_count_d = sat_add(wr_count_q, 2'd1);
    end else begin
      wr_count_d = wr_count_q;
    end
    if (rd_acc_s) begin
      rd_count_d = sat_add(rd_count_q, 2'd1);
    end else begin
      rd_count_d = rd_count_q;
    end
    drop_count_d = sat_add(drop_count_q, drop_inc_s);
  end

  // Pipeline, counters and done flag registers; reset flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q        <= {RD_LATENCY{1'b0}};
      calib_done_q <= 1'b0;
      wr_count_q   <= 32'd0;
      rd_count_q   <= 32'd0;
      drop_count_q <= 32'd0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= {PW{1'b0}};
      end
    end else begin
      vld_q        <= vld_d;
      calib_done_q <= calib_done_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign app.init_calib_complete = calib_done_q;
  assign app.user_app_rd_valid   = vld_q[RD_LATENCY-1];
  assign app.user_app_rd_data    = dat_q[RD_LATENCY-1];
  assign app.wr_count            = wr_count_q;
  assign app.rd_count            = rd_count_q;
  assign app.drop_count          = drop_count_q;

endmodule

// File: tb/tb_qdr_user_app_responder.sv
// Self-checking bench for qdr_user_app_responder: a queue/array model is
// updated on every rising edge and compared against the DUT on every falling
// edge; directed scenarios add literal expectations.
module tb_qdr_user_app_responder;

  localparam int AW  = 19;
  localparam int PW  = 144;
  localparam int LAT = 4;
  localparam int CAL = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  qdr_user_app_responder_if #(.AW(AW), .PW(PW)) app ();

  qdr_user_app_responder #(
    .QDR_ADDR_WIDTH(AW), .QDR_DATA_WIDTH(36), .QDR_BURST_LENGTH(4),
    .MEM_ADDR_BITS(12), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL)
  ) dut (
    .clk(clk), .resetn(resetn), .app(app)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    logic [PW-1:0] data;
  } rd_t;

  logic [PW-1:0] mmem [4096];
  rd_t           mq [$];
  logic [PW-1:0] seen [$];
  int  cyc   = 0;
  int  since = 0;     // rising edges seen with resetn high since last reset
  int  mwr, mrd, mdrop;
  bit  live  = 1'b0;

  // Model update: ready once CAL+1 edges have passed since reset release.
  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (!resetn) begin
      live  = 1'b1;
      since = 0;
      mwr = 0; mrd = 0; mdrop = 0;
      mq.delete();
    end else begin
      acc = (since >= CAL + 1);
      if (since < 100000) since++;
      while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
      if (app.user_app_rd_cmd) begin
        if (acc) begin
          mq.push_back('{due: cyc + LAT - 1, data: mmem[app.user_app_rd_addr[11:0]]});
          mrd++;
        end else begin
          mdrop++;
        end
      end
      if (app.user_app_wr_cmd) begin
        if (acc) begin
          mmem[app.user_app_wr_addr[11:0]] = app.user_app_wr_data;
          mwr++;
        end else begin
          mdrop++;
        end
      end
    end
  end

  // Compare DUT against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    logic          ev;
    logic [PW-1:0] ed;
    if (live) begin
      ev = (mq.size() > 0 && mq[0].due == cyc);
      ed = ev ? mq[0].data : {PW{1'b0}};
      chk("rd_valid",   {{(PW-1){1'b0}}, app.user_app_rd_valid}, {{(PW-1){1'b0}}, ev});
      chk("rd_data",    app.user_app_rd_data, ed);
      chk("init_calib", {{(PW-1){1'b0}}, app.init_calib_complete},
                        {{(PW-1){1'b0}}, (since >= CAL + 1)});
      chk("wr_count",   PW'(app.wr_count),   PW'(mwr));
      chk("rd_count",   PW'(app.rd_count),   PW'(mrd));
      chk("drop_count", PW'(app.drop_count), PW'(mdrop));
      if (app.user_app_rd_valid === 1'b1) seen.push_back(app.user_app_rd_data);
    end
  end

  // ---------------- stimulus ----------------
  int tk  = 0;
  int tk0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    tk++;
  endtask

  task automatic idle(input int n);
    app.user_app_wr_cmd = 1'b0;
    app.user_app_rd_cmd = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cmd(input bit w, input logic [AW-1:0] wa, input logic [PW-1:0] wd,
                     input bit r, input logic [AW-1:0] ra);
    app.user_app_wr_cmd  = w;
    app.user_app_wr_addr = wa;
    app.user_app_wr_data = wd;
    app.user_app_rd_cmd  = r;
    app.user_app_rd_addr = ra;
    tick();
    app.user_app_wr_cmd = 1'b0;
    app.user_app_rd_cmd = 1'b0;
  endtask

  task automatic wait_ready();
    while (app.init_calib_complete !== 1'b1 && (tk - tk0) < 300) tick();
    chk("calib_delay", PW'(tk - tk0), PW'(65));
  endtask

  initial begin
    resetn = 1'b0;
    app.user_app_wr_cmd  = 1'b0;
    app.user_app_rd_cmd  = 1'b0;
    app.user_app_wr_addr = '0;
    app.user_app_rd_addr = '0;
    app.user_app_wr_data = '0;
    repeat (3) tick();
    chk("reset_init", {{(PW-1){1'b0}}, app.init_calib_complete}, {PW{1'b0}});
    resetn = 1'b1;
    tk0 = tk;

    // Calibration: commands before ready are dropped (1 + 2).
    idle(10);
    cmd(1'b1, 19'd5, 144'hDEAD, 1'b0, 19'd0);
    idle(8);
    cmd(1'b1, 19'd6, 144'hBEEF, 1'b1, 19'd6);
    wait_ready();
    chk("drop_after_calib", PW'(app.drop_count), PW'(3));
    chk("wr_after_calib",   PW'(app.wr_count),   PW'(0));

    // Write/read latency.
    cmd(1'b1, 19'd5, 144'h1234, 1'b0, 19'd0);
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd5);
    tick(); tick();
    chk("lat_early_valid", {{(PW-1){1'b0}}, app.user_app_rd_valid}, {PW{1'b0}});
    tick();
    chk("lat_valid", {{(PW-1){1'b0}}, app.user_app_rd_valid}, 144'd1);
    chk("lat_data",  app.user_app_rd_data, 144'h1234);
    tick();
    chk("lat_one_wide", {{(PW-1){1'b0}}, app.user_app_rd_valid}, {PW{1'b0}});
    chk("lat_wr_count", PW'(app.wr_count), PW'(1));
    chk("lat_rd_count", PW'(app.rd_count), PW'(1));

    // Streaming.
    for (int i = 0; i < 16; i++) cmd(1'b1, AW'(i), PW'(i), 1'b0, 19'd0);
    seen.delete();
    for (int i = 0; i < 16; i++) cmd(1'b0, 19'd0, 144'h0, 1'b1, AW'(i));
    idle(6);
    chk("stream_len", PW'(seen.size()), PW'(16));
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("stream_data", seen[i], PW'(i));

    // Collision: read-before-write.
    cmd(1'b1, 19'd7, 144'hAAAA, 1'b0, 19'd0);
    seen.delete();
    cmd(1'b1, 19'd7, 144'hBBBB, 1'b1, 19'd7);
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd7);
    idle(6);
    chk("coll_len", PW'(seen.size()), PW'(2));
    if (seen.size() == 2) begin
      chk("coll_old", seen[0], 144'hAAAA);
      chk("coll_new", seen[1], 144'hBBBB);
    end

    // Aliasing plus simultaneous write/read to different addresses.
    cmd(1'b1, 19'h01005, 144'hCCCC, 1'b0, 19'd0);
    seen.delete();
    cmd(1'b1, 19'd100, 144'hDDDD, 1'b1, 19'h00005);
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd100);
    idle(6);
    chk("alias_len", PW'(seen.size()), PW'(2));
    if (seen.size() == 2) begin
      chk("alias_data", seen[0], 144'hCCCC);
      chk("diff_addr",  seen[1], 144'hDDDD);
    end
    cmd(1'b1, 19'd9, 144'h99, 1'b0, 19'd0);
    chk("tot_wr_count", PW'(app.wr_count), PW'(22));
    chk("tot_rd_count", PW'(app.rd_count), PW'(21));

    // Reset mid-flight: third read coincides with reset.
    seen.delete();
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd0);
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd1);
    resetn = 1'b0;
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd2);
    tick();
    chk("rst_wr_count",   PW'(app.wr_count),   PW'(0));
    chk("rst_rd_count",   PW'(app.rd_count),   PW'(0));
    chk("rst_drop_count", PW'(app.drop_count), PW'(0));
    chk("rst_init", {{(PW-1){1'b0}}, app.init_calib_complete}, {PW{1'b0}});
    resetn = 1'b1;
    tk0 = tk;
    idle(5);
    cmd(1'b1, 19'd9, 144'hBAD, 1'b0, 19'd0);
    wait_ready();
    chk("rst_no_valid", PW'(seen.size()), PW'(0));
    chk("rst_drop",     PW'(app.drop_count), PW'(1));

    // Memory survives reset and the dropped write did not land.
    seen.delete();
    cmd(1'b0, 19'd0, 144'h0, 1'b1, 19'd9);
    idle(6);
    chk("persist_len", PW'(seen.size()), PW'(1));
    if (seen.size() == 1) chk("persist_data", seen[0], 144'h99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
